// File: rtl/emergency_pkg.sv
// emergency_pkg: shared timing constants and lockout state encoding for the emergency subsystem
package emergency_pkg;
  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int LOCKOUT_CYCLES_DEFAULT  = 25_000_000;
  localparam int STUCK_CYCLES_DEFAULT    = 250_000_000;

  typedef enum logic {
    LOCK_READY  = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser, stability debouncer and registered rise pulse
module input_debouncer
  import emergency_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // synchronise, then flip the stable level only after the input has disagreed for the full window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= r_sync;
        r_rise   <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;
endmodule

// File: rtl/emergency_input_conditioner.sv
// emergency_input_conditioner: debounced panic pulse with lockout and stuck detect, plus debounced danger level
module emergency_input_conditioner
  import emergency_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic panic_raw,
  input  logic danger_raw,
  output logic panic_pulse,
  output logic danger_level,
  output logic danger_rise,
  output logic panic_stuck
);
  localparam int LW = cnt_width(LOCKOUT_CYCLES);
  localparam int SW = cnt_width(STUCK_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  logic          w_panic_level;
  logic          w_panic_rise;
  logic          w_pulse;
  lock_state_e   r_state;
  lock_state_e   w_state_nxt;
  logic [LW-1:0] r_lock_cnt;
  logic [LW-1:0] w_lock_cnt_nxt;
  logic [SW-1:0] r_stuck_cnt;
  logic [SW-1:0] w_stuck_cnt_nxt;
  logic          r_stuck;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_panic (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (panic_raw),
    .stable (w_panic_level),
    .rise   (w_panic_rise)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_danger (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (danger_raw),
    .stable (danger_level),
    .rise   (danger_rise)
  );

  // lockout next-state: accept a rise only in READY; rises while LOCKED or on the return cycle are dropped
  always_comb begin
    w_pulse        = (r_state == LOCK_READY) && w_panic_rise;
    w_state_nxt    = w_pulse ? LOCK_LOCKED :
                     (r_state == LOCK_LOCKED && r_lock_cnt == '0) ? LOCK_READY : r_state;
    w_lock_cnt_nxt = w_pulse ? LOCK_LAST :
                     (r_state == LOCK_LOCKED && r_lock_cnt != '0) ? r_lock_cnt - LW'(1) : r_lock_cnt;
  end

  // lockout state and countdown registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LOCK_READY;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // saturating high-time counter for the debounced panic level
  always_comb begin
    w_stuck_cnt_nxt = !w_panic_level ? '0 :
                      (r_stuck_cnt == STUCK_LAST) ? r_stuck_cnt : r_stuck_cnt + SW'(1);
  end

  // stuck flag follows the counter reaching its limit and drops one cycle after the level falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stuck_cnt <= '0;
      r_stuck     <= 1'b0;
    end else begin
      r_stuck_cnt <= w_stuck_cnt_nxt;
      r_stuck     <= w_panic_level && (w_stuck_cnt_nxt == STUCK_LAST);
    end
  end

  assign panic_pulse = w_pulse;
  assign panic_stuck = r_stuck;
endmodule

// File: tb/tb_emergency_input_conditioner.sv
// tb_emergency_input_conditioner: directed scenarios with hand-computed cycle expectations
module tb_emergency_input_conditioner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic panic_raw = 1'b0;
  logic danger_raw = 1'b0;
  logic panic_pulse, danger_level, danger_rise, panic_stuck;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  emergency_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (16),
    .STUCK_CYCLES   (32)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .panic_raw   (panic_raw),
    .danger_raw  (danger_raw),
    .panic_pulse (panic_pulse),
    .danger_level(danger_level),
    .danger_rise (danger_rise),
    .panic_stuck (panic_stuck)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    panic_raw = 1'b0;
    danger_raw = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) step();
    vectors++;
    if ({panic_pulse, danger_level, danger_rise, panic_stuck} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held outs=%b exp=0000", {panic_pulse, danger_level, danger_rise, panic_stuck});
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      vectors++;
      if ({panic_pulse, danger_level, danger_rise, panic_stuck} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d outs=%b exp=0000", k, {panic_pulse, danger_level, danger_rise, panic_stuck});
      end
    end
  endtask

  task automatic test_clean_press;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      panic_raw = (k <= 10);
      step();
      vectors++;
      if (panic_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL clean_press k=%0d got=%b exp=%b", k, panic_pulse, (k == 6));
      end
    end
  endtask

  task automatic test_bounce;
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      panic_raw = ((k <= 20) && (((k - 1) / 2) % 2 == 0)) || (k >= 31 && k <= 40);
      step();
      vectors++;
      if (panic_pulse !== (k == 36) || panic_stuck !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce k=%0d pulse=%b stuck=%b exp_pulse=%b exp_stuck=0", k, panic_pulse, panic_stuck, (k == 36));
      end
    end
  endtask

  task automatic test_lockout;
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      panic_raw = (k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 21 && k <= 24);
      step();
      vectors++;
      if (panic_pulse !== (k == 6 || k == 26)) begin
        miscompares++;
        $display("FAIL lockout k=%0d got=%b exp=%b", k, panic_pulse, (k == 6 || k == 26));
      end
    end
  endtask

  task automatic test_lockout_edge(input int start, input int exp_cycle);
    do_reset();
    for (int k = 1; k <= start + 12; k++) begin
      panic_raw = (k <= 4) || (k >= start && k <= start + 3);
      step();
      vectors++;
      if (panic_pulse !== (k == 6 || k == exp_cycle)) begin
        miscompares++;
        $display("FAIL lockout_edge start=%0d k=%0d got=%b exp=%b", start, k, panic_pulse, (k == 6 || k == exp_cycle));
      end
    end
  endtask

  task automatic test_stuck;
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      panic_raw = (k <= 50);
      step();
      vectors++;
      if (panic_stuck !== (k >= 37 && k <= 56) || panic_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL stuck k=%0d stuck=%b pulse=%b exp_stuck=%b exp_pulse=%b", k, panic_stuck, panic_pulse, (k >= 37 && k <= 56), (k == 6));
      end
    end
  endtask

  task automatic test_danger;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      danger_raw = (k <= 10);
      panic_raw = (k <= 6);
      step();
      vectors++;
      if (danger_level !== (k >= 6 && k <= 15) || danger_rise !== (k == 6) || panic_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL danger k=%0d level=%b rise=%b pulse=%b exp=%b%b%b", k, danger_level, danger_rise, panic_pulse,
                 (k >= 6 && k <= 15), (k == 6), (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      panic_raw = 1'b1;
      step();
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({panic_pulse, danger_level, danger_rise, panic_stuck} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_count outs=%b exp=0000", {panic_pulse, danger_level, danger_rise, panic_stuck});
    end
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      vectors++;
      if (panic_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL reset_mid_count_repress k=%0d got=%b exp=%b", k, panic_pulse, (k == 6));
      end
    end
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      panic_raw = (k <= 4);
      danger_raw = 1'b1;
      step();
    end
    vectors++;
    if (danger_level !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_locked_pre level=%b exp=1", danger_level);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({panic_pulse, danger_level, danger_rise, panic_stuck} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_locked outs=%b exp=0000", {panic_pulse, danger_level, danger_rise, panic_stuck});
    end
    repeat (2) step();
    panic_raw = 1'b0;
    danger_raw = 1'b0;
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      panic_raw = (k <= 4);
      step();
      vectors++;
      if (panic_pulse !== (k == 6)) begin
        miscompares++;
        $display("FAIL reset_locked_repress k=%0d got=%b exp=%b", k, panic_pulse, (k == 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_lockout();
    test_lockout_edge(17, 0);
    test_lockout_edge(18, 23);
    test_stuck();
    test_danger();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
